seg_display_ctrl: RTL and testbench

Parametrised multi-digit seven-segment display controller for the reaction-timer board. It latches a frame of 5-bit symbol codes on a load strobe, then decodes each digit to active-low segments. Per-digit decimal point, blanking and blinking are supported, along with leading-zero suppression and lamp test. Outputs are registered and drive the board's static HEX displays directly. It supersedes the single-digit combinational decoder.

---
 rtl/seg_display_ctrl.sv | 144 ++++++++++++++
 tb/tb_seg_display_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seg_display_ctrl.sv
// Multi-digit seven-segment controller: latches a symbol frame on load and drives registered active-low segments.
// Latency: load at edge k is shown after edge k+1; lamp_test and blink take one edge. No backpressure: every load is accepted.
// Optional blinking is built in with SEG_BLINK_EN; otherwise blink_phase stays 0 and blink_in is ignored.
module seg_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      load,
    input  logic [5*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    input  logic [NUM_DIGITS-1:0]     blink_in,
    input  logic                      lzs_en,
    input  logic                      lamp_test,
    output logic [8*NUM_DIGITS-1:0]   hex_out,
    output logic                      updated,
    output logic                      blink_phase
);

    typedef struct packed {
        logic [5*NUM_DIGITS-1:0] codes;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   blank;
        logic [NUM_DIGITS-1:0]   blink;
        logic                    lzs;
    } frame_t;

    frame_t                    shadow;
    logic                      load_d;
    logic [NUM_DIGITS-1:0]     blink_mask;
    logic [8*NUM_DIGITS-1:0]   hex_nxt;

    function automatic logic [7:0] seg_decode(input logic [4:0] code);
        logic [7:0] seg;
        seg = 8'hFF;
        case (code)
            5'd0:  seg = 8'hC0;
            5'd1:  seg = 8'hF9;
            5'd2:  seg = 8'hA4;
            5'd3:  seg = 8'hB0;
            5'd4:  seg = 8'h99;
            5'd5:  seg = 8'h92;
            5'd6:  seg = 8'h82;
            5'd7:  seg = 8'hF8;
            5'd8:  seg = 8'h80;
            5'd9:  seg = 8'h90;
            5'd10: seg = 8'h88;
            5'd11: seg = 8'h83;
            5'd12: seg = 8'hC6;
            5'd13: seg = 8'hA1;
            5'd14: seg = 8'h86;
            5'd15: seg = 8'h8E;
            5'd16: seg = 8'hAF;
            5'd17: seg = 8'h90;
            5'd18: seg = 8'hA3;
            5'd19: seg = 8'h89;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    // Blank-until-first-load comes from the all-ones blank field at reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow.codes <= '0;
            shadow.dp    <= '0;
            shadow.blank <= '1;
            shadow.blink <= '0;
            shadow.lzs   <= 1'b0;
            load_d       <= 1'b0;
            updated      <= 1'b0;
        end else begin
            load_d  <= load;
            updated <= load_d;
            if (load) begin
                shadow.codes <= digits_in;
                shadow.dp    <= dp_in;
                shadow.blank <= blank_in;
                shadow.blink <= blink_in;
                shadow.lzs   <= lzs_en;
            end
        end
    end

`ifdef SEG_BLINK_EN
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CNT_W-1:0] blink_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    assign blink_mask = shadow.blink & {NUM_DIGITS{blink_phase}};
`else
    logic unused_blink;

    assign blink_phase  = 1'b0;
    assign blink_mask   = '0;
    assign unused_blink = ^shadow.blink;
`endif

    // Zero run is scanned from the leftmost digit; digit 0 always survives.
    always_comb begin
        logic       in_run;
        logic [4:0] code;
        logic [7:0] seg;
        hex_nxt = '1;
        in_run  = shadow.lzs;
        code    = '0;
        seg     = 8'hFF;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            code = shadow.codes[5*i +: 5];
            seg  = seg_decode(code);
            if (shadow.dp[i])
                seg[7] = 1'b0;
            if (code != 5'd0 || shadow.dp[i] || i == 0)
                in_run = 1'b0;
            if (lamp_test)
                seg = 8'h00;
            else if (shadow.blank[i] || blink_mask[i] || in_run)
                seg = 8'hFF;
            hex_nxt[8*i +: 8] = seg;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            hex_out <= '1;
        else
            hex_out <= hex_nxt;
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl: directed frames, a per-cycle reference model and literal spot checks.
module tb_seg_display_ctrl;

    localparam int ND = 6;
    localparam int BD = 4;
`ifdef SEG_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    localparam logic [7:0] SEGTAB [0:31] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E,
        8'hAF, 8'h90, 8'hA3, 8'h89, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
        8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              load = 1'b0;
    logic [5*ND-1:0]   digits_in = '0;
    logic [ND-1:0]     dp_in = '0;
    logic [ND-1:0]     blank_in = '0;
    logic [ND-1:0]     blink_in = '0;
    logic              lzs_en = 1'b0;
    logic              lamp_test = 1'b0;
    logic [8*ND-1:0]   hex_out;
    logic              updated;
    logic              blink_phase;

    int checks = 0;
    int errors = 0;

    seg_display_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(BD)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .digits_in(digits_in),
        .dp_in(dp_in), .blank_in(blank_in), .blink_in(blink_in), .lzs_en(lzs_en),
        .lamp_test(lamp_test), .hex_out(hex_out), .updated(updated), .blink_phase(blink_phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame contents as plain arrays, phase from edges counted since reset.
    int          m_code [ND];
    bit          m_dp [ND], m_blank [ND], m_blink [ND];
    bit          m_lzs, m_pend, e_phase, e_upd;
    int          n_edges;
    logic [8*ND-1:0] e_hex;

    function automatic logic [8*ND-1:0] model_hex(input bit lamp, input bit phase);
        logic [8*ND-1:0] r;
        logic [7:0]      v;
        bit              in_run;
        r = '1;
        in_run = m_lzs;
        for (int i = ND - 1; i >= 0; i--) begin
            v = SEGTAB[m_code[i]];
            if (m_dp[i]) v = v & 8'h7F;
            if (m_code[i] != 0 || m_dp[i] || i == 0) in_run = 0;
            if (lamp) v = 8'h00;
            else if (m_blank[i] || (m_blink[i] && phase) || in_run) v = 8'hFF;
            r[8*i +: 8] = v;
        end
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ND; i++) begin
                m_code[i] = 0; m_dp[i] = 0; m_blank[i] = 1; m_blink[i] = 0;
            end
            m_lzs = 0; m_pend = 0; e_phase = 0; e_upd = 0; n_edges = 0;
            e_hex = '1;
        end else begin
            e_hex  = model_hex(lamp_test, e_phase);
            e_upd  = m_pend;
            m_pend = load;
            if (load) begin
                for (int i = 0; i < ND; i++) begin
                    m_code[i]  = int'(digits_in[5*i +: 5]);
                    m_dp[i]    = dp_in[i];
                    m_blank[i] = blank_in[i];
                    m_blink[i] = blink_in[i];
                end
                m_lzs = lzs_en;
            end
            n_edges++;
            e_phase = BLINK_ON && (((n_edges / BD) % 2) == 1);
        end
    end

    always @(negedge clk) begin
        chk("model_hex", 64'(hex_out), 64'(e_hex));
        chk("model_updated", 64'(updated), 64'(e_upd));
        chk("model_phase", 64'(blink_phase), 64'(e_phase));
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input string nm, input logic [29:0] c, input logic [5:0] d,
                           input logic [5:0] b, input logic [5:0] k, input logic z,
                           input logic [47:0] exp);
        @(posedge clk); #1;
        load = 1'b1; digits_in = c; dp_in = d; blank_in = b; blink_in = k; lzs_en = z;
        @(posedge clk); #1;
        load = 1'b0;
        @(posedge clk); #1;
        chk(nm, 64'(hex_out), 64'(exp));
        chk({nm, "_upd_hi"}, 64'(updated), 64'd1);
        @(posedge clk); #1;
        chk({nm, "_upd_lo"}, 64'(updated), 64'd0);
    endtask

    initial begin
        #12;
        chk("reset_hex", 64'(hex_out), 64'h0000_FFFF_FFFF_FFFF);
        chk("reset_upd", 64'(updated), 64'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        cycles(5);
        chk("idle_dark", 64'(hex_out), 64'h0000_FFFF_FFFF_FFFF);

        do_load("frame_543210", {5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0}, 6'b000100, 6'b0, 6'b0, 1'b0,
                48'h92_99_B0_24_F9_C0);
        do_load("lzs_000100", {5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd0}, 6'b0, 6'b0, 6'b0, 1'b1,
                48'hFF_FF_FF_F9_C0_C0);
        do_load("lzs_all0", 30'd0, 6'b0, 6'b0, 6'b0, 1'b1, 48'hFF_FF_FF_FF_FF_C0);
        do_load("lzs_dp3", {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd7}, 6'b001000, 6'b0, 6'b0, 1'b1,
                48'hFF_FF_40_C0_C0_F8);
        do_load("codes_16_25", {5'd16, 5'd17, 5'd18, 5'd19, 5'd25, 5'd20}, 6'b000001, 6'b0, 6'b0, 1'b0,
                48'hAF_90_A3_89_FF_7F);

        // Back-to-back loads: frame A then frame B, updated high two cycles.
        @(posedge clk); #1;
        load = 1'b1; digits_in = {5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1}; dp_in = '0; blank_in = '0; lzs_en = 1'b0;
        @(posedge clk); #1;
        digits_in = {5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2};
        @(posedge clk); #1;
        load = 1'b0;
        chk("b2b_frame_a", 64'(hex_out), 64'h0000_F9F9_F9F9_F9F9);
        chk("b2b_upd_a", 64'(updated), 64'd1);
        @(posedge clk); #1;
        chk("b2b_frame_b", 64'(hex_out), 64'h0000_A4A4_A4A4_A4A4);
        chk("b2b_upd_b", 64'(updated), 64'd1);

        do_load("lamp_frame", {5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0}, 6'b000100, 6'b000010, 6'b0, 1'b0,
                48'h92_99_B0_24_FF_C0);
        lamp_test = 1'b1;
        cycles(1);
        chk("lamp_on", 64'(hex_out), 64'h0);
        lamp_test = 1'b0;
        cycles(1);
        chk("lamp_off", 64'(hex_out), 64'h0000_9299_B024_FFC0);

        do_load("blink_load", {5'd20, 5'd20, 5'd20, 5'd20, 5'd20, 5'd8}, 6'b0, 6'b0, 6'b000001, 1'b0,
                48'hFF_FF_FF_FF_FF_80);
        cycles(13);
`ifndef SEG_BLINK_EN
        chk("blink_disabled_steady", 64'(hex_out), 64'h0000_FFFF_FFFF_FF80);
`endif

        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        chk("midrst_hex", 64'(hex_out), 64'h0000_FFFF_FFFF_FFFF);
        chk("midrst_phase", 64'(blink_phase), 64'd0);
        chk("midrst_upd", 64'(updated), 64'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        cycles(6);
        chk("post_rst_dark", 64'(hex_out), 64'h0000_FFFF_FFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
